// File: rtl/branch_predictor_pkg.sv
// Shared types for the front-end predictor and the branch/jump unit:
// control-flow kinds, the fetch-side prediction record, the execute-side
// resolution record and the BTB entry layout.
package OoO_pkg;

    typedef enum logic [2:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JAL,
        CF_JALR,
        CF_CALL,
        CF_RET
    } cf_t;

    typedef struct packed {
        cf_t         cf;
        logic [31:0] predict_addr;
    } bpu_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf_type;
    } bju_t;

    // Widest tag occurs at the smallest legal BTB (4 entries): pc[31:3].
    // Smaller tags are stored zero-extended.
    localparam int TAG_MAX_W = 29;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        cf_t                  cf;
        logic                 is_rv16;
    } btb_entry_t;

    localparam logic [1:0] BHT_INIT = 2'b01;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle of the branch predictor. The master side
// drives lookups, resolutions and flushes; the slave side returns the
// prediction.
interface branch_predictor_if;
    logic               fetch_valid;
    logic [31:0]        fetch_pc;
    OoO_pkg::bpu_t      bpu;
    OoO_pkg::bju_t      bju;
    logic               flush;

    modport master (output fetch_valid, fetch_pc, bju, flush, input bpu);
    modport slave  (input fetch_valid, fetch_pc, bju, flush, output bpu);
endinterface

// File: rtl/ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; count saturates at DEPTH. Flush empties the stack.
module ras #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      stack_q [DEPTH];
    logic [31:0]      stack_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ptr points at the next free slot; the top lives one below it
    assign top_o   = stack_q[ptr_q - 1'b1];
    assign empty_o = (cnt_q == '0);

    // next pointer/count/storage; flush beats push/pop
    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        stack_d = stack_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            stack_d[ptr_q] = data_i;
            ptr_d          = ptr_q + 1'b1;
            if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Front-end branch predictor: direct-mapped BTB + 2-bit BHT, combinational
// lookup, trained by execute-stage resolutions (read-before-write).
// Optional return-address stack enabled by BRANCH_PREDICTOR_RAS_EN.
module branch_predictor
    import OoO_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    output bpu_t        bpu_o,
    input  bju_t        bju_i,
    input  logic        flush_i
);
    localparam int BTB_W = $clog2(BTB_ENTRIES);
    localparam int BHT_W = $clog2(BHT_ENTRIES);

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];
    logic [1:0] bht_q [BHT_ENTRIES];
    logic [1:0] bht_d [BHT_ENTRIES];

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [31:0] pc);
        return TAG_MAX_W'(pc >> (BTB_W + 1));
    endfunction

    btb_entry_t f_ent;
    logic       f_hit;
    logic [1:0] f_ctr;

    assign f_ent = btb_q[fetch_pc_i[BTB_W:1]];
    assign f_hit = f_ent.valid && (f_ent.tag == tag_of(fetch_pc_i));
    assign f_ctr = bht_q[fetch_pc_i[BHT_W:1]];

`ifdef BRANCH_PREDICTOR_RAS_EN
    logic        ras_push, ras_pop, ras_empty;
    logic [31:0] ras_top;

    ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .flush_i (flush_i),
        .data_i  (fetch_pc_i + (f_ent.is_rv16 ? 32'd2 : 32'd4)),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );

    // a predicted call pushes its return address, a predicted return pops
    always_comb begin
        ras_push = fetch_valid_i && f_hit && (f_ent.cf == CF_CALL);
        ras_pop  = fetch_valid_i && f_hit && (f_ent.cf == CF_RET) && !ras_empty;
    end
`endif

    // combinational prediction from pre-update state
    always_comb begin
        bpu_o.cf           = CF_NONE;
        bpu_o.predict_addr = '0;
        if (fetch_valid_i && f_hit) begin
            case (f_ent.cf)
                CF_BRANCH: if (f_ctr[1]) begin
                    bpu_o.cf           = CF_BRANCH;
                    bpu_o.predict_addr = f_ent.target;
                end
                CF_JAL, CF_JALR, CF_CALL: begin
                    bpu_o.cf           = f_ent.cf;
                    bpu_o.predict_addr = f_ent.target;
                end
                CF_RET: begin
                    bpu_o.cf           = CF_RET;
                    bpu_o.predict_addr = f_ent.target;
`ifdef BRANCH_PREDICTOR_RAS_EN
                    // empty stack falls back to the BTB target
                    if (!ras_empty) bpu_o.predict_addr = ras_top;
`endif
                end
                default: ;
            endcase
        end
    end

    // training from execute; aliasing entries are simply overwritten
    always_comb begin
        btb_d = btb_q;
        bht_d = bht_q;
        if (bju_i.valid) begin
            case (bju_i.cf_type)
                CF_BRANCH: begin
                    if (bju_i.is_taken) begin
                        if (bht_q[bju_i.pc[BHT_W:1]] != 2'b11)
                            bht_d[bju_i.pc[BHT_W:1]] = bht_q[bju_i.pc[BHT_W:1]] + 2'd1;
                        // resolution record has no size info: entries assume 4-byte instructions
                        btb_d[bju_i.pc[BTB_W:1]] = '{1'b1, tag_of(bju_i.pc),
                                                     bju_i.target_address, CF_BRANCH, 1'b0};
                    end else if (bht_q[bju_i.pc[BHT_W:1]] != 2'b00) begin
                        bht_d[bju_i.pc[BHT_W:1]] = bht_q[bju_i.pc[BHT_W:1]] - 2'd1;
                    end
                end
                CF_JALR, CF_CALL, CF_RET: if (bju_i.is_mispredict) begin
                    btb_d[bju_i.pc[BTB_W:1]] = '{1'b1, tag_of(bju_i.pc),
                                                 bju_i.target_address, bju_i.cf_type, 1'b0};
                end
                default: ;
            endcase
        end
    end

    // BTB/BHT state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i] <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_INIT;
        end else begin
            btb_q <= btb_d;
            bht_q <= bht_d;
        end
    end

    // bit 0 of the PCs never indexes; flush only matters with the RAS
    logic unused_ok;
    assign unused_ok = ^{flush_i, fetch_pc_i[0], bju_i.pc[0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor. Define
// BRANCH_PREDICTOR_RAS_EN to also exercise the return-address stack.
module tb_branch_predictor;
    import OoO_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    branch_predictor_if bif();

    branch_predictor dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_valid_i (bif.fetch_valid),
        .fetch_pc_i    (bif.fetch_pc),
        .bpu_o         (bif.bpu),
        .bju_i         (bif.bju),
        .flush_i       (bif.flush)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bif.fetch_valid = 1'b0;
        bif.fetch_pc    = '0;
        bif.bju         = '0;
        bif.flush       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one-cycle lookup; the clock edge inside lets RAS push/pop happen once
    task automatic lookup(input logic [31:0] pc, output cf_t cf, output logic [31:0] a);
        @(negedge clk);
        bif.fetch_valid = 1'b1;
        bif.fetch_pc    = pc;
        #1;
        cf = bif.bpu.cf;
        a  = bif.bpu.predict_addr;
        @(posedge clk);
        #1 bif.fetch_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic mis, input logic tk, input cf_t t);
        @(negedge clk);
        bif.bju = '{1'b1, pc, tgt, mis, tk, t};
        @(posedge clk);
        #1 bif.bju.valid = 1'b0;
    endtask

    task automatic test_reset();
        cf_t cf; logic [31:0] a;
        do_reset();
        lookup(32'h8000_0000, cf, a);
        n_cmp++;
        if (cf !== CF_NONE || a !== 32'h0) begin
            n_err++; $display("FAIL reset_lookup: got cf=%0d addr=%h want cf=%0d addr=0", cf, a, CF_NONE);
        end
    endtask

    task automatic test_branch_train();
        cf_t cf; logic [31:0] a;
        cf_t         exp_cf [4] = '{CF_BRANCH, CF_BRANCH, CF_BRANCH, CF_NONE};
        logic [31:0] exp_a  [4] = '{32'h8000_0040, 32'h8000_0040, 32'h8000_0040, 32'h0};
        logic        tk     [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        // counter 01->10->11->10->01
        for (int i = 0; i < 4; i++) begin
            train(32'h8000_0010, 32'h8000_0040, 1'b0, tk[i], CF_BRANCH);
            lookup(32'h8000_0010, cf, a);
            n_cmp++;
            if (cf !== exp_cf[i] || a !== exp_a[i]) begin
                n_err++; $display("FAIL branch_step%0d: got cf=%0d addr=%h want cf=%0d addr=%h", i, cf, a, exp_cf[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_fetch_invalid();
        train(32'h8000_0010, 32'h8000_0040, 1'b0, 1'b1, CF_BRANCH);
        @(negedge clk);
        bif.fetch_valid = 1'b0;
        bif.fetch_pc    = 32'h8000_0010;
        #1;
        n_cmp++;
        if (bif.bpu.cf !== CF_NONE || bif.bpu.predict_addr !== 32'h0) begin
            n_err++; $display("FAIL fetch_invalid: got cf=%0d addr=%h want cf=%0d addr=0", bif.bpu.cf, bif.bpu.predict_addr, CF_NONE);
        end
    endtask

    task automatic test_saturation();
        cf_t cf; logic [31:0] a;
        // floor: 01->00 (not taken), ->01 (taken, BTB written), ->10
        cf_t exp_lo [3] = '{CF_NONE, CF_NONE, CF_BRANCH};
        logic tk_lo [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            train(32'h8000_0020, 32'h8000_0080, 1'b0, tk_lo[i], CF_BRANCH);
            lookup(32'h8000_0020, cf, a);
            n_cmp++;
            if (cf !== exp_lo[i] || (cf == CF_BRANCH && a !== 32'h8000_0080)) begin
                n_err++; $display("FAIL sat_low%0d: got cf=%0d addr=%h want cf=%0d", i, cf, a, exp_lo[i]);
            end
        end
        // ceiling: three taken stays 11, one not-taken leaves 10
        repeat (3) train(32'h8000_0030, 32'h8000_00C0, 1'b0, 1'b1, CF_BRANCH);
        train(32'h8000_0030, 32'h8000_00C0, 1'b0, 1'b0, CF_BRANCH);
        lookup(32'h8000_0030, cf, a);
        n_cmp++;
        if (cf !== CF_BRANCH || a !== 32'h8000_00C0) begin
            n_err++; $display("FAIL sat_high: got cf=%0d addr=%h want cf=%0d addr=800000c0", cf, a, CF_BRANCH);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bif.bju         = '{1'b1, 32'h8000_0100, 32'h8000_1234, 1'b1, 1'b0, CF_JALR};
        bif.fetch_valid = 1'b1;
        bif.fetch_pc    = 32'h8000_0100;
        #1;
        n_cmp++;
        if (bif.bpu.cf !== CF_NONE || bif.bpu.predict_addr !== 32'h0) begin
            n_err++; $display("FAIL same_cycle: got cf=%0d addr=%h want cf=%0d addr=0", bif.bpu.cf, bif.bpu.predict_addr, CF_NONE);
        end
        @(posedge clk);
        #1 bif.bju.valid = 1'b0;
        n_cmp++;
        if (bif.bpu.cf !== CF_JALR || bif.bpu.predict_addr !== 32'h8000_1234) begin
            n_err++; $display("FAIL next_cycle: got cf=%0d addr=%h want cf=%0d addr=80001234", bif.bpu.cf, bif.bpu.predict_addr, CF_JALR);
        end
        bif.fetch_valid = 1'b0;
    endtask

    task automatic test_no_update();
        cf_t cf; logic [31:0] a;
        train(32'h8000_0200, 32'h0000_1111, 1'b1, 1'b1, CF_JAL);
        lookup(32'h8000_0200, cf, a);
        n_cmp++;
        if (cf !== CF_NONE || a !== 32'h0) begin
            n_err++; $display("FAIL jal_no_write: got cf=%0d addr=%h want cf=%0d addr=0", cf, a, CF_NONE);
        end
        train(32'h8000_0204, 32'h0000_2222, 1'b0, 1'b1, CF_JALR);
        lookup(32'h8000_0204, cf, a);
        n_cmp++;
        if (cf !== CF_NONE || a !== 32'h0) begin
            n_err++; $display("FAIL jalr_correct_no_write: got cf=%0d addr=%h want cf=%0d addr=0", cf, a, CF_NONE);
        end
    endtask

    task automatic test_alias();
        cf_t cf; logic [31:0] a;
        train(32'h8000_0090, 32'h8000_00A0, 1'b0, 1'b1, CF_BRANCH);
        lookup(32'h8000_0010, cf, a);
        n_cmp++;
        if (cf !== CF_NONE || a !== 32'h0) begin
            n_err++; $display("FAIL alias_evict: got cf=%0d addr=%h want cf=%0d addr=0", cf, a, CF_NONE);
        end
        lookup(32'h8000_0090, cf, a);
        n_cmp++;
        if (cf !== CF_BRANCH || a !== 32'h8000_00A0) begin
            n_err++; $display("FAIL alias_new: got cf=%0d addr=%h want cf=%0d addr=800000a0", cf, a, CF_BRANCH);
        end
    endtask

    task automatic test_ret();
        cf_t cf; logic [31:0] a;
        do_reset();
        train(32'h0000_0200, 32'h0000_1000, 1'b1, 1'b0, CF_CALL);
        train(32'h0000_0240, 32'h0000_0500, 1'b1, 1'b0, CF_RET);
        lookup(32'h0000_0200, cf, a);
        n_cmp++;
        if (cf !== CF_CALL || a !== 32'h0000_1000) begin
            n_err++; $display("FAIL call_lookup: got cf=%0d addr=%h want cf=%0d addr=00001000", cf, a, CF_CALL);
        end
`ifdef BRANCH_PREDICTOR_RAS_EN
        lookup(32'h0000_0240, cf, a);
        n_cmp++;
        if (cf !== CF_RET || a !== 32'h0000_0204) begin
            n_err++; $display("FAIL ras_ret: got cf=%0d addr=%h want cf=%0d addr=00000204", cf, a, CF_RET);
        end
`endif
        // stack now empty (or absent): BTB target
        lookup(32'h0000_0240, cf, a);
        n_cmp++;
        if (cf !== CF_RET || a !== 32'h0000_0500) begin
            n_err++; $display("FAIL ret_btb: got cf=%0d addr=%h want cf=%0d addr=00000500", cf, a, CF_RET);
        end
    endtask

`ifdef BRANCH_PREDICTOR_RAS_EN
    task automatic test_ras_depth();
        cf_t cf; logic [31:0] a;
        logic [31:0] exp_a [5] = '{32'h218, 32'h214, 32'h210, 32'h20C, 32'h500};
        for (int i = 0; i < 5; i++)
            train(32'h204 + 32'(4 * i), 32'h1000, 1'b1, 1'b0, CF_CALL);
        for (int i = 0; i < 5; i++) lookup(32'h204 + 32'(4 * i), cf, a);
        for (int i = 0; i < 5; i++) begin
            lookup(32'h0000_0240, cf, a);
            n_cmp++;
            if (cf !== CF_RET || a !== exp_a[i]) begin
                n_err++; $display("FAIL ras_pop%0d: got cf=%0d addr=%h want cf=%0d addr=%h", i, cf, a, CF_RET, exp_a[i]);
            end
        end
    endtask

    task automatic test_flush_wrap();
        cf_t cf; logic [31:0] a;
        lookup(32'h0000_0200, cf, a);
        @(negedge clk);
        bif.flush = 1'b1;
        @(posedge clk);
        #1 bif.flush = 1'b0;
        lookup(32'h0000_0240, cf, a);
        n_cmp++;
        if (cf !== CF_RET || a !== 32'h0000_0500) begin
            n_err++; $display("FAIL ras_flush: got cf=%0d addr=%h want cf=%0d addr=00000500", cf, a, CF_RET);
        end
        train(32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 1'b0, CF_CALL);
        lookup(32'hFFFF_FFFC, cf, a);
        lookup(32'h0000_0240, cf, a);
        n_cmp++;
        if (cf !== CF_RET || a !== 32'h0) begin
            n_err++; $display("FAIL ras_wrap: got cf=%0d addr=%h want cf=%0d addr=00000000", cf, a, CF_RET);
        end
    endtask
`endif

    task automatic test_reset_mid();
        cf_t cf; logic [31:0] a;
        do_reset();
        lookup(32'h0000_0240, cf, a);
        n_cmp++;
        if (cf !== CF_NONE || a !== 32'h0) begin
            n_err++; $display("FAIL reset_discards: got cf=%0d addr=%h want cf=%0d addr=0", cf, a, CF_NONE);
        end
    endtask

    initial begin
        test_reset();
        test_branch_train();
        test_fetch_invalid();
        test_saturation();
        test_back_to_back();
        test_no_update();
        test_alias();
        test_ret();
`ifdef BRANCH_PREDICTOR_RAS_EN
        test_ras_depth();
        test_flush_wrap();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
